// File: rtl/register_file_sb.sv
// Register file with two combinational read ports, one write port, a PC-alias register
// and per-register busy (scoreboard) tracking with pending count and sticky WAW error flag.
module register_file_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int PC_IDX = 2**ADDR_W - 1,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] a1,
   input  logic [ADDR_W-1:0] a2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic [ADDR_W-1:0] a3,
   input  logic [DATA_W-1:0] wd3,
   input  logic              we3,
   input  logic [DATA_W-1:0] r15,
   input  logic              issue,
   input  logic [ADDR_W-1:0] issue_a,
   output logic              busy1,
   output logic              busy2,
   output logic              stall,
   output logic [ADDR_W:0]   pend_cnt,
   output logic              waw_err
);

   localparam int NREG = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);
   localparam logic BYP = (BYPASS != 0);

   logic [DATA_W-1:0] regs [NREG];
   logic [NREG-1:0]   busy;
   logic [NREG-1:0]   busy_next;
   logic              waw_hit;

   // PC alias has priority over forwarding, forwarding over the stored value.
   always_comb begin
      rd1 = regs[a1];
      rd2 = regs[a2];
      if (a1 == PC_A)
         rd1 = r15;
      else if (BYP && we3 && (a3 == a1))
         rd1 = wd3;
      if (a2 == PC_A)
         rd2 = r15;
      else if (BYP && we3 && (a3 == a2))
         rd2 = wd3;
   end

   always_comb begin
      busy1 = busy[a1] && !(BYP && we3 && (a3 == a1)) && (a1 != PC_A);
      busy2 = busy[a2] && !(BYP && we3 && (a3 == a2)) && (a2 != PC_A);
      stall = busy1 || busy2;
   end

   // Issue is applied after the write-back clear so a same-register collision stays busy.
   always_comb begin
      busy_next = busy;
      if (we3)
         busy_next[a3] = 1'b0;
      if (issue && (issue_a != PC_A))
         busy_next[issue_a] = 1'b1;
      waw_hit = issue && (issue_a != PC_A) && busy[issue_a] && !(we3 && (a3 == issue_a));
   end

   always_comb begin
      pend_cnt = '0;
      for (int i = 0; i < NREG; i++)
         pend_cnt = pend_cnt + {{ADDR_W{1'b0}}, busy[i]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else if (we3 && (a3 != PC_A)) begin
         regs[a3] <= wd3;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy    <= '0;
         waw_err <= 1'b0;
      end else begin
         busy <= busy_next;
         if (waw_hit)
            waw_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: directed vector table, reset corner sequence, and a
// randomized run compared against an array-based reference model (bypass on and off).
module tb_register_file_sb;

   localparam logic [3:0] PC = 4'd15;

   logic        clk;
   logic        rst_n;
   logic [3:0]  a1, a2, a3, issue_a;
   logic [31:0] wd3, r15;
   logic        we3, issue;

   logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
   logic        busy1, busy2, stall, waw_err;
   logic        nb_busy1, nb_busy2, nb_stall, nb_waw_err;
   logic [4:0]  pend_cnt, nb_pend_cnt;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_regs [16];
   bit          m_busy [16];
   bit          m_waw;

   typedef struct {
      logic [3:0]  a1, a2, a3;
      logic [31:0] wd3;
      logic        we3, issue;
      logic [3:0]  issue_a;
      logic [31:0] e_rd1, e_rd2;
      logic        e_busy1, e_busy2;
      logic [4:0]  e_pend;
      logic        e_waw;
      logic [31:0] e_nb_rd1;
      logic        e_nb_busy2;
   } vec_t;

   vec_t vecs [17];

   register_file_sb #(.DATA_W(32), .ADDR_W(4), .BYPASS(1)) dut (
      .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
      .a3(a3), .wd3(wd3), .we3(we3), .r15(r15), .issue(issue), .issue_a(issue_a),
      .busy1(busy1), .busy2(busy2), .stall(stall), .pend_cnt(pend_cnt), .waw_err(waw_err)
   );

   register_file_sb #(.DATA_W(32), .ADDR_W(4), .BYPASS(0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .rd1(nb_rd1), .rd2(nb_rd2),
      .a3(a3), .wd3(wd3), .we3(we3), .r15(r15), .issue(issue), .issue_a(issue_a),
      .busy1(nb_busy1), .busy2(nb_busy2), .stall(nb_stall), .pend_cnt(nb_pend_cnt),
      .waw_err(nb_waw_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 16; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      m_waw = 1'b0;
   endtask

   // Reference behaviour of one clock edge, taken from the current inputs.
   task automatic model_edge();
      if (issue && issue_a != PC && m_busy[issue_a] && !(we3 && a3 == issue_a))
         m_waw = 1'b1;
      if (we3 && a3 != PC)
         m_regs[a3] = wd3;
      if (we3)
         m_busy[a3] = 1'b0;
      if (issue && issue_a != PC)
         m_busy[issue_a] = 1'b1;
   endtask

   function automatic logic [31:0] exp_rd(input logic [3:0] a, input bit byp);
      if (a == PC) return r15;
      if (byp && we3 && a3 == a) return wd3;
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input logic [3:0] a, input bit byp);
      if (a == PC) return 1'b0;
      return m_busy[a] && !(byp && we3 && a3 == a);
   endfunction

   function automatic logic [4:0] exp_pend();
      int n = 0;
      for (int i = 0; i < 16; i++) n += int'(m_busy[i]);
      return 5'(n);
   endfunction

   task automatic check_model(input string tag);
      check_output({tag, ".rd1"},   rd1,      exp_rd(a1, 1));
      check_output({tag, ".rd2"},   rd2,      exp_rd(a2, 1));
      check_output({tag, ".busy1"}, busy1,    exp_busy(a1, 1));
      check_output({tag, ".busy2"}, busy2,    exp_busy(a2, 1));
      check_output({tag, ".stall"}, stall,    exp_busy(a1, 1) | exp_busy(a2, 1));
      check_output({tag, ".pend"},  pend_cnt, exp_pend());
      check_output({tag, ".waw"},   waw_err,  m_waw);
      check_output({tag, ".nb_rd1"},   nb_rd1,   exp_rd(a1, 0));
      check_output({tag, ".nb_rd2"},   nb_rd2,   exp_rd(a2, 0));
      check_output({tag, ".nb_busy1"}, nb_busy1, exp_busy(a1, 0));
      check_output({tag, ".nb_busy2"}, nb_busy2, exp_busy(a2, 0));
   endtask

   task automatic drive_idle();
      we3 = 1'b0; issue = 1'b0; a3 = '0; wd3 = '0; issue_a = '0;
   endtask

   task automatic tick();
      if (rst_n) model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      drive_idle();
      m_reset();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic apply_stimulus(input vec_t v);
      a1 = v.a1; a2 = v.a2; a3 = v.a3; wd3 = v.wd3;
      we3 = v.we3; issue = v.issue; issue_a = v.issue_a;
   endtask

   initial begin
      vecs[0]  = '{0, 15, 0, 0, 0, 0, 0,   0, 24, 0, 0, 0, 0,  0, 0};
      vecs[1]  = '{0, 15, 2, 15, 1, 0, 0,  0, 24, 0, 0, 0, 0,  0, 0};
      vecs[2]  = '{2, 15, 0, 0, 0, 0, 0,  15, 24, 0, 0, 0, 0, 15, 0};
      vecs[3]  = '{2, 15, 15, 70, 1, 0, 0, 15, 24, 0, 0, 0, 0, 15, 0};
      vecs[4]  = '{15, 2, 0, 0, 0, 0, 0,  24, 15, 0, 0, 0, 0, 24, 0};
      vecs[5]  = '{3, 0, 3, 33, 1, 0, 0,  33, 0, 0, 0, 0, 0,  0, 0};
      vecs[6]  = '{3, 0, 3, 70, 1, 0, 0,  70, 0, 0, 0, 0, 0, 33, 0};
      vecs[7]  = '{3, 0, 0, 0, 0, 0, 0,   70, 0, 0, 0, 0, 0, 70, 0};
      vecs[8]  = '{0, 5, 0, 0, 0, 1, 5,    0, 0, 0, 0, 0, 0,  0, 0};
      vecs[9]  = '{0, 5, 0, 0, 0, 0, 0,    0, 0, 0, 1, 1, 0,  0, 1};
      vecs[10] = '{0, 5, 5, 55, 1, 0, 0,   0, 55, 0, 0, 1, 0,  0, 1};
      vecs[11] = '{0, 5, 0, 0, 0, 0, 0,    0, 55, 0, 0, 0, 0,  0, 0};
      vecs[12] = '{0, 4, 0, 0, 0, 1, 4,    0, 0, 0, 0, 0, 0,  0, 0};
      vecs[13] = '{0, 4, 0, 0, 0, 1, 4,    0, 0, 0, 1, 1, 0,  0, 1};
      vecs[14] = '{0, 4, 4, 44, 1, 0, 0,   0, 44, 0, 0, 1, 1,  0, 1};
      vecs[15] = '{0, 6, 6, 66, 1, 1, 6,   0, 66, 0, 0, 0, 1,  0, 0};
      vecs[16] = '{0, 6, 0, 0, 0, 0, 0,    0, 66, 0, 1, 1, 1,  0, 1};

      a1 = '0; a2 = '0; r15 = 32'd24;
      apply_reset();

      foreach (vecs[i]) begin
         apply_stimulus(vecs[i]);
         #1;
         check_output($sformatf("vec%0d.rd1", i),   rd1,      vecs[i].e_rd1);
         check_output($sformatf("vec%0d.rd2", i),   rd2,      vecs[i].e_rd2);
         check_output($sformatf("vec%0d.busy1", i), busy1,    vecs[i].e_busy1);
         check_output($sformatf("vec%0d.busy2", i), busy2,    vecs[i].e_busy2);
         check_output($sformatf("vec%0d.stall", i), stall,    vecs[i].e_busy1 | vecs[i].e_busy2);
         check_output($sformatf("vec%0d.pend", i),  pend_cnt, vecs[i].e_pend);
         check_output($sformatf("vec%0d.waw", i),   waw_err,  vecs[i].e_waw);
         check_output($sformatf("vec%0d.nb_rd1", i),   nb_rd1,   vecs[i].e_nb_rd1);
         check_output($sformatf("vec%0d.nb_busy2", i), nb_busy2, vecs[i].e_nb_busy2);
         tick();
      end

      // Asynchronous reset in the middle of activity, then first edge afterwards.
      apply_reset();
      a1 = 4'd2; a2 = 4'd1;
      we3 = 1'b1; a3 = 4'd2; wd3 = 32'd99;
      tick();
      drive_idle(); issue = 1'b1; issue_a = 4'd1; tick();
      issue_a = 4'd2; tick();
      issue_a = 4'd3; tick();
      drive_idle();
      #1;
      check_output("seq.pend_before_rst", pend_cnt, 5'd3);
      check_output("seq.rd1_before_rst",  rd1,      32'd99);
      check_output("seq.busy2_before_rst", busy2,   1'b1);
      rst_n = 1'b0;
      #1;
      m_reset();
      check_output("seq.pend_async_rst",  pend_cnt, 5'd0);
      check_output("seq.rd1_async_rst",   rd1,      32'd0);
      check_output("seq.busy2_async_rst", busy2,    1'b0);
      check_output("seq.waw_async_rst",   waw_err,  1'b0);
      we3 = 1'b1; a3 = 4'd2; wd3 = 32'd7; issue = 1'b1; issue_a = 4'd3;
      tick();
      drive_idle();
      #1;
      check_output("seq.pend_rst_edge", pend_cnt, 5'd0);
      check_output("seq.rd1_rst_edge",  rd1,      32'd0);
      rst_n = 1'b1;
      #1;
      we3 = 1'b1; a3 = 4'd2; wd3 = 32'd5; issue = 1'b1; issue_a = PC;
      tick();
      drive_idle();
      #1;
      check_output("seq.pend_pc_issue", pend_cnt, 5'd0);
      check_output("seq.rd1_first_edge", rd1,     32'd5);
      check_model("seq.model");

      // Randomized run against the reference model.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 49) == 0) begin
            rst_n = 1'b0;
            #1;
            m_reset();
            check_model("rnd.rst");
            rst_n = 1'b1;
         end
         a1      = 4'($urandom_range(0, 15));
         a2      = 4'($urandom_range(0, 15));
         a3      = ($urandom_range(0, 3) == 0) ? a1 : 4'($urandom_range(0, 15));
         wd3     = $urandom;
         r15     = $urandom;
         we3     = 1'($urandom_range(0, 1));
         issue   = 1'($urandom_range(0, 1));
         issue_a = ($urandom_range(0, 3) == 0) ? a3 : 4'($urandom_range(0, 15));
         #1;
         check_model($sformatf("rnd%0d", n));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/register_file_sb.md
REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 32, which sets the register and data width.
REQ-002 The block SHALL have the parameter ADDR_W, default 4, which sets the address width; there SHALL be 2^ADDR_W architectural registers.
REQ-003 The block SHALL have the parameter PC_IDX, default 2^ADDR_W-1, which is the index of the program-counter register.
REQ-004 The block SHALL have the parameter BYPASS, default 1, where 1 enables write-to-read forwarding and 0 disables it.
REQ-005 CLK  in  1  system clock; all state SHALL update on its rising edge.
REQ-006 RST_N  in  1  reset, asynchronous and active-low.
REQ-007 A1, A2  in  ADDR_W  read-port addresses.
REQ-008 RD1, RD2  out  DATA_W  read data for A1 and A2 respectively.
REQ-009 A3  in  ADDR_W  write address.
REQ-010 WD3  in  DATA_W  write data.
REQ-011 WE3  in  1  write enable.
REQ-012 R15  in  DATA_W  externally supplied PC value, returned whenever PC_IDX is read.
REQ-013 ISSUE, ISSUE_A  in  1, ADDR_W  marks register ISSUE_A as pending a write.
REQ-014 BUSY1, BUSY2  out  1  the register read on port 1 / port 2 is pending.
REQ-015 STALL  out  1  BUSY1 OR BUSY2.
REQ-016 PEND_CNT  out  ADDR_W+1  number of registers currently marked busy.
REQ-017 WAW_ERR  out  1  sticky flag indicating an issue was made to a register that was already busy.

Function
REQ-018 Reads SHALL be combinational, with zero-cycle latency from A1/A2 to RD1/RD2.
REQ-019 When An==PC_IDX, RDn SHALL equal R15 regardless of WE3 or the stored contents.
REQ-020 When BYPASS=1, WE3=1, A3==An and An!=PC_IDX, RDn SHALL equal WD3 in the same cycle.
REQ-021 In all other cases RDn SHALL equal the stored value reg[An].
REQ-022 On a rising CLK edge with WE3=1 and A3!=PC_IDX, reg[A3] SHALL take the value WD3.
REQ-023 A write with A3==PC_IDX SHALL store nothing.
REQ-024 Each register SHALL have a busy bit.
REQ-025 On a rising edge, ISSUE=1 SHALL set busy[ISSUE_A]; ISSUE with ISSUE_A==PC_IDX SHALL be ignored.
REQ-026 On a rising edge, WE3=1 SHALL clear busy[A3].
REQ-027 When ISSUE and WE3 target the same register in the same cycle, the busy bit SHALL end set (the issue wins).
REQ-028 BUSYn SHALL equal busy[An] AND NOT (BYPASS AND WE3 AND A3==An); BUSYn SHALL be 0 when An==PC_IDX.
REQ-029 PEND_CNT SHALL equal the population count of the busy register bits and SHALL reflect the state after the last edge.
REQ-030 PEND_CNT SHALL never exceed 2^ADDR_W-1, because the PC register cannot be busy.
REQ-031 WAW_ERR SHALL be set at an edge when ISSUE=1, ISSUE_A!=PC_IDX, and busy[ISSUE_A] is 1 and is not being cleared by WE3 in that same cycle.
REQ-032 Once set, WAW_ERR SHALL remain set until reset.
REQ-033 With WE3=0 and ISSUE=0, the state SHALL hold.

Reset
REQ-034 While RST_N=0, all registers SHALL be 0, all busy bits SHALL be 0, PEND_CNT SHALL be 0 and WAW_ERR SHALL be 0, immediately and without waiting for CLK.
REQ-035 Reset asserted mid-operation SHALL discard any write or issue in that cycle.
REQ-036 RD1/RD2 during reset SHALL follow REQ-019..REQ-021 with stored values of 0.
REQ-037 The first edge after RST_N rises SHALL operate normally.

Verification
REQ-038 After reset, A1=0, A2=PC_IDX, R15=24 -> RD1=0, RD2=24, STALL=0, PEND_CNT=0.
REQ-039 WE3=1, A3=2, WD3=15, one edge; then A1=2 -> RD1=15; a write of 70 to A3=PC_IDX -> reading PC_IDX still returns R15.
REQ-040 BYPASS=1: WE3=1, A3=3, WD3=70, A1=3 in the same cycle -> RD1=70 before the edge; repeat with BYPASS=0 -> RD1 equals the old reg[3].
REQ-041 ISSUE to register 5, edge -> PEND_CNT=1; A2=5 -> BUSY2=1, STALL=1; then WE3 with A3=5 -> BUSY2=0 combinationally (BYPASS=1), and after the edge PEND_CNT=0.
REQ-042 ISSUE 4, edge, ISSUE 4 again, edge -> WAW_ERR=1, held until reset; ISSUE 6 together with WE3 to A3=6, edge -> busy[6]=1.
REQ-043 Issue registers 1..3, then drop RST_N between clock edges -> PEND_CNT=0 and reg[2]=0 immediately; ISSUE to PC_IDX -> PEND_CNT unchanged.
